// File: rtl/seg7_scan_mux_if.sv
// Pattern-bank / scanned-display bus for seg7_scan_mux.
// The slave side is the scanner; the master side owns the patterns and
// watches the pins. Optional: SEG7_SCAN_BRIGHT_EN adds a 3-bit bright input.
interface seg7_scan_mux_if;
    logic [6:0] pat0, pat1, pat2, pat3, pat4, pat5, pat6, pat7;
`ifdef SEG7_SCAN_BRIGHT_EN
    logic [2:0] bright;
`endif
    logic [6:0] seg_o;
    logic [7:0] dig_o;
    logic [2:0] cur_dig;
    logic       frame_start;

    modport master (
        output pat0, pat1, pat2, pat3, pat4, pat5, pat6, pat7,
`ifdef SEG7_SCAN_BRIGHT_EN
        output bright,
`endif
        input  seg_o, dig_o, cur_dig, frame_start
    );

    modport slave (
        input  pat0, pat1, pat2, pat3, pat4, pat5, pat6, pat7,
`ifdef SEG7_SCAN_BRIGHT_EN
        input  bright,
`endif
        output seg_o, dig_o, cur_dig, frame_start
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexes an 8-digit 7-segment pattern bank onto a
// shared segment bus plus one-hot digit select. The bank is snapshotted once
// per frame (no tearing) and each slot opens with a blanking gap (no ghosting).
// All pins are registered and lag div_cnt/slot by one cycle.
// Optional feature macro: SEG7_SCAN_BRIGHT_EN (per-frame brightness window).
module seg7_scan_mux #(
    parameter int DIV            = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic            clk50,
    input  logic            rst,
    seg7_scan_mux_if.slave  bus
);
    localparam int              CW        = $clog2(DIV);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(DIV - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYC);
    localparam logic [6:0]      SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic [7:0]      DIG_OFF   = {8{DIG_ACTIVE_LOW}};

    logic [CW-1:0]   r_div_cnt;
    logic [2:0]      r_slot;
    logic [7:0][6:0] r_shadow;
    logic            r_load_pending;
    logic [6:0]      r_seg_o;
    logic [7:0]      r_dig_o;
    logic [2:0]      r_cur_dig;
    logic            r_frame_start;

    logic            w_wrap;
    logic            w_snap;
    logic            w_drive;
    logic [6:0]      w_seg_on;
    logic [7:0]      w_dig_on;

    assign w_wrap = (r_div_cnt == LAST_CNT);
    // Snapshot only at the very end of slot 7, or once right after reset.
    assign w_snap = r_load_pending | (w_wrap & (r_slot == 3'd7));

`ifdef SEG7_SCAN_BRIGHT_EN
    localparam int unsigned WIN = (DIV - BLANK_CYC) >> 3;
    logic [2:0]    r_bright;
    logic [CW-1:0] w_drv_off;
    logic [31:0]   w_drv_lim;

    assign w_drv_off = r_div_cnt - BLANK_END;
    assign w_drv_lim = WIN * (32'(r_bright) + 32'd1);
    // bright=7 is defined as the full window even when DIV-BLANK_CYC is not a multiple of 8.
    assign w_drive   = (r_div_cnt >= BLANK_END) &&
                       ((r_bright == 3'd7) || (32'(w_drv_off) < w_drv_lim));

    // Brightness is latched on the same edges as the pattern bank.
    always_ff @(posedge clk50) begin
        if (rst)         r_bright <= 3'd7;
        else if (w_snap) r_bright <= bus.bright;
    end
`else
    assign w_drive = (r_div_cnt >= BLANK_END);
`endif

    assign w_seg_on = w_drive ? r_shadow[r_slot] : 7'd0;
    assign w_dig_on = w_drive ? (8'd1 << r_slot) : 8'd0;

    // Slot timebase: div_cnt wraps every DIV cycles and advances the slot.
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_div_cnt      <= '0;
            r_slot         <= 3'd0;
            r_load_pending <= 1'b1;
        end else begin
            r_div_cnt      <= w_wrap ? '0 : r_div_cnt + CW'(1);
            r_load_pending <= 1'b0;
            if (w_wrap) r_slot <= r_slot + 3'd1;
        end
    end

    // Pattern bank shadow, digit 0 in entry 0.
    always_ff @(posedge clk50) begin
        if (rst)         r_shadow <= '0;
        else if (w_snap) r_shadow <= {bus.pat7, bus.pat6, bus.pat5, bus.pat4,
                                      bus.pat3, bus.pat2, bus.pat1, bus.pat0};
    end

    // Pin registers: one cycle behind the timebase, polarity applied here.
    always_ff @(posedge clk50) begin
        if (rst) begin
            r_seg_o       <= SEG_OFF;
            r_dig_o       <= DIG_OFF;
            r_cur_dig     <= 3'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_seg_o       <= w_seg_on ^ SEG_OFF;
            r_dig_o       <= w_dig_on ^ DIG_OFF;
            r_cur_dig     <= r_slot;
            r_frame_start <= (r_div_cnt == '0) && (r_slot == 3'd0);
        end
    end

    assign bus.seg_o       = r_seg_o;
    assign bus.dig_o       = r_dig_o;
    assign bus.cur_dig     = r_cur_dig;
    assign bus.frame_start = r_frame_start;
endmodule
